// File: rtl/evr_event_fifo_logger.sv
// Event-receiver logger: timestamps enabled event codes into a FIFO with a
// show-ahead valid/ready readout, wrap or stop-on-full, sticky overflow.
module evr_event_fifo_logger #(
  parameter int ADDR_WIDTH = 10,
  parameter int TICK_WIDTH = 32
) (
  input  logic                  evrClk,
  input  logic                  evrRst_n,
  input  logic [7:0]            evrChar,
  input  logic                  evrCharIsK,
  input  logic                  ctlWrite,
  input  logic [31:0]           ctlData,
  input  logic                  maskWrite,
  input  logic [7:0]            maskCode,
  input  logic                  maskEnable,
  output logic [31:0]           status,
  output logic [15:0]           dropCount,
  output logic                  rdValid,
  input  logic                  rdReady,
  output logic [7:0]            rdEvent,
  output logic [TICK_WIDTH-1:0] rdTicks
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef struct packed {
    logic [7:0]            code;
    logic [TICK_WIDTH-1:0] ticks;
  } entry_t;

  logic [TICK_WIDTH-1:0] tickCnt;
  logic [7:0]            capChar;
  logic                  capIsK;
  logic                  capMaskOk;
  logic [TICK_WIDTH-1:0] capTick;
  logic                  qValid;
  entry_t                qEntry;
  logic                  running;
  logic                  stopMode;
  logic                  overflow;
  logic [255:0]          eventMask;
  entry_t                mem [DEPTH];
  logic [ADDR_WIDTH-1:0] memRd;
  logic [ADDR_WIDTH-1:0] memWr;
  logic [CW-1:0]         memCount;
  logic [CW-1:0]         occupancy;
  entry_t                outEntry;
  logic                  clearNow;
  logic                  full;
  logic                  empty;
  logic                  popOut;
  logic                  loadOut;
  logic                  accept;
  logic                  dropEvt;
  logic                  discard;
  logic                  memWrEn;
  logic                  unusedCtl;

  // The output stage is a separate register; mem only holds entries behind it,
  // so wrap-mode discard is just an extra advance of the mem read pointer.
  assign clearNow  = ctlWrite && ctlData[29];
  assign occupancy = memCount + CW'(rdValid);
  assign full      = (occupancy == CW'(DEPTH));
  assign empty     = (occupancy == '0);
  assign popOut    = rdValid && rdReady;
  assign loadOut   = (memCount != '0) && (!rdValid || rdReady);
  assign accept    = qValid && (!full || popOut);
  assign dropEvt   = qValid && full && !popOut;
  assign discard   = dropEvt && !stopMode;
  assign memWrEn   = accept || discard;
  assign unusedCtl = ^ctlData[28:0];

  assign status  = {running, stopMode, overflow, full, empty, 3'b000,
                    4'(ADDR_WIDTH), 4'b0000, 16'(occupancy)};
  assign rdEvent = outEntry.code;
  assign rdTicks = outEntry.ticks;

  // NOTE: the storage array is deliberately not reset; pointers and count
  // alone decide which entries are live, and resetting it would block RAM inference.
  always_ff @(posedge evrClk) begin
    if (memWrEn) mem[memWr] <= qEntry;
  end

  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      tickCnt   <= '0;
      capChar   <= '0;
      capIsK    <= 1'b0;
      capMaskOk <= 1'b0;
      capTick   <= '0;
      qValid    <= 1'b0;
      qEntry    <= '0;
      running   <= 1'b0;
      stopMode  <= 1'b0;
      overflow  <= 1'b0;
      dropCount <= '0;
      eventMask <= {{255{1'b1}}, 1'b0};
      memRd     <= '0;
      memWr     <= '0;
      memCount  <= '0;
      rdValid   <= 1'b0;
      outEntry  <= '0;
    end else begin
      tickCnt   <= tickCnt + TICK_WIDTH'(1);
      capChar   <= evrChar;
      capIsK    <= evrCharIsK;
      capMaskOk <= eventMask[evrChar];
      capTick   <= tickCnt;
      qEntry    <= '{code: capChar, ticks: capTick};
      if (maskWrite) eventMask[maskCode] <= maskEnable;
      if (ctlWrite) begin
        running  <= ctlData[31];
        stopMode <= ctlData[30];
      end
      if (clearNow) begin
        qValid    <= 1'b0;
        memRd     <= '0;
        memWr     <= '0;
        memCount  <= '0;
        rdValid   <= 1'b0;
        overflow  <= 1'b0;
        dropCount <= '0;
      end else begin
        qValid   <= running && !capIsK && (capChar != 8'd0) && capMaskOk;
        if (memWrEn) memWr <= memWr + ADDR_WIDTH'(1);
        memRd    <= memRd + ADDR_WIDTH'(loadOut) + ADDR_WIDTH'(discard);
        memCount <= memCount + CW'(memWrEn) - CW'(loadOut) - CW'(discard);
        if (loadOut) begin
          rdValid  <= 1'b1;
          outEntry <= mem[memRd];
        end else if (popOut) begin
          rdValid <= 1'b0;
        end
        if (dropEvt) begin
          overflow <= 1'b1;
          if (dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
        end
      end
    end
  end
endmodule

// File: doc/evr_event_fifo_logger.md
# evr_event_fifo_logger

Single-clock event-receiver logger that timestamps selected event codes into a FIFO with a show-ahead valid/ready readout. It sits in the EVR clock domain, between the decoded 8b/10b character stream and a system-side readout bridge. Compared with a plain circular capture buffer, it adds a per-code enable mask, selectable wrap or stop-on-full mode, sticky overflow, a saturating drop counter and configurable timestamp width.

## Interface
- ADDR_WIDTH, 10: log2 of FIFO depth; legal range 4..15; DEPTH = 2^ADDR_WIDTH entries.
- TICK_WIDTH, 32: timestamp width; legal range 16..48.

- evrClk  in  1  EVR recovered clock; all logic on its rising edge.
- evrRst_n  in  1  reset, asynchronous assert, active-low; release synchronised externally.
- evrChar  in  8  decoded character.
- evrCharIsK  in  1  evrChar is a K (comma/control) character.
- ctlWrite  in  1  one-cycle strobe; latches ctlData.
- ctlData  in  32  [31] run, [30] stopMode (1 = stop-on-full, 0 = wrap), [29] clear (self-clearing action).
- maskWrite  in  1  one-cycle strobe; writes one enable-mask bit.
- maskCode  in  8  event code addressed by maskWrite.
- maskEnable  in  1  new enable value for maskCode.
- status  out  32  [31] running, [30] stopMode, [29] overflow, [28] full, [27] empty, [23:20] ADDR_WIDTH, [15:0] occupancy (zero-extended); other bits 0.
- dropCount  out  16  events lost since last clear; saturates at 0xFFFF.
- rdValid  out  1  output stage holds an entry.
- rdReady  in  1  consumer accepts entry when rdValid && rdReady.
- rdEvent  out  8  event code of output entry.
- rdTicks  out  TICK_WIDTH  timestamp of output entry.

## Operation
- Reset: running=0, stopMode=0, overflow=0, occupancy=0, empty=1, full=0, dropCount=0, rdValid=0, rdEvent=0, rdTicks=0, tick counter=0, mask = all 1 except code 0.
- Tick counter: free-running TICK_WIDTH bits, +1 per cycle, wraps modulo 2^TICK_WIDTH; unaffected by run/clear.
- Capture stage: evrChar/evrCharIsK/tick registered. Qualified event = running && !isK && char != 0 && mask[char]. Code 0 is never logged regardless of mask.
- Entry = {code, tick value registered with the character}.
- Occupancy counts all unread entries, including output stage; max DEPTH. full = (occupancy == DEPTH), empty = (occupancy == 0).
- Qualified event when not full: written, occupancy +1.
- Qualified event when full, stopMode=1: dropped; dropCount +1 (saturating); overflow set.
- Qualified event when full, stopMode=0: the oldest entry not in the output stage is discarded and the new entry written; occupancy unchanged; dropCount +1; overflow set. An entry presented with rdValid=1 is never altered or discarded until popped.
- Pop and qualified write in the same cycle while full: pop frees a slot; write accepted with no drop or overflow.
- Run cleared: capture stops; stored contents, overflow and dropCount are retained and remain readable.
- clear=1 on ctlWrite: FIFO flushed (occupancy 0, rdValid 0), overflow=0, dropCount=0. Run and stopMode take the written values in the same strobe. A qualified event in the clear cycle is discarded, and no drop is counted.
- Mask writes take effect for characters arriving at evrChar on the cycle after the maskWrite edge.
- Output stage: show-ahead. rdEvent/rdTicks hold stable while rdValid && !rdReady. After a pop, the next entry (if any) follows with no bubble when RAM has entries (back-to-back pops at 1 per cycle).

## Timing
- Character at evrChar on edge k: its timestamp is the counter value sampled at edge k.
- Empty FIFO: rdValid rises after edge k+3, with rdEvent/rdTicks valid.
- Status reflects a write or pop one cycle after the causing edge; full/empty/occupancy change together.
- ctlWrite/maskWrite are effective from the next edge; status[31:30] update after that edge.
- Sustained throughput: 1 write and 1 pop per cycle concurrently.

## Test plan
- Reset, run=1, stopMode=0; inject codes 0x01, 0x7F, K 0xBC, 0x00 on consecutive cycles -> exactly 2 entries (0x01, 0x7F), ticks differ by 1, first rdValid 3 cycles after 0x01.
- Mask code 0x7F off; inject 0x7F then 0x20 -> only 0x20 logged; re-enable 0x7F and inject it -> logged.
- ADDR_WIDTH=4, stopMode=1, rdReady=0; inject 20 events -> occupancy 16, full=1, overflow=1, dropCount=4, read-out yields events 1..16 in order.
- Same, stopMode=0 -> dropCount=4; read-out yields event 1 (held in output stage), then events 6..20.
- Full FIFO, rdReady=1 and qualified event in the same cycle -> no drop, occupancy stays 16, dropCount unchanged.
- Mid-stream clear with run=1, then assert evrRst_n low asynchronously mid-burst -> each time, rdValid=0, occupancy=0, dropCount=0 the cycle after clear / immediately on reset.
